// File: rtl/alsu_cmd_seq_if.sv
// Command, ALSU drive/return and response bundle for alsu_cmd_seq.
// The slave side is the sequencer; the master side is the harness/consumer.
interface alsu_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [3:0]  cmd_rep;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_out;
  logic [15:0] rsp_leds;
  logic        rsp_inv;
  logic [7:0]  err_cnt;

  modport slave (
    input  cmd_valid, cmd_data, cmd_rep, alsu_out, alsu_leds, rsp_ready,
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
           alsu_direction, rsp_valid, rsp_out, rsp_leds, rsp_inv, err_cnt
  );

  modport master (
    output cmd_valid, cmd_data, cmd_rep, alsu_out, alsu_leds, rsp_ready,
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in,
           alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
           alsu_direction, rsp_valid, rsp_out, rsp_leds, rsp_inv, err_cnt
  );
endinterface

// File: rtl/alsu_cmd_seq.sv
// Drives one packed command onto the ALSU for cmd_rep+1 cycles, waits LAT cycles,
// buffers the result. Define ALSU_CMD_SEQ_ERRCNT_EN to build the invalid-command counter.
module alsu_cmd_seq #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  alsu_cmd_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [15:0] drv;
  logic        inv, inv_q, rsp_vld, accept;
  logic [2:0]  op;

  assign op     = bus.cmd_data[9:7];
  assign accept = (state == IDLE) && !rsp_vld && bus.cmd_valid;
  assign inv    = !bus.cmd_data[2] && !bus.cmd_data[1] &&
                  (op[2:1] == 2'b11 ||
                   ((bus.cmd_data[4] || bus.cmd_data[3]) && op inside {[3'b010:3'b101]}));

  assign bus.cmd_ready = (state == IDLE) && !rsp_vld;
  assign bus.rsp_valid = rsp_vld;

  // drv mirrors the command packing so the field split happens in one place
  assign {bus.alsu_A, bus.alsu_B, bus.alsu_opcode, bus.alsu_cin, bus.alsu_serial_in,
          bus.alsu_red_op_A, bus.alsu_red_op_B, bus.alsu_bypass_A, bus.alsu_bypass_B,
          bus.alsu_direction} = drv;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept)         state_nxt = DRIVE;
      DRIVE: if (cnt == 4'd0)    state_nxt = WAIT;
      WAIT:  if (cnt == 4'd0)    state_nxt = RESP;
      RESP:  if (bus.rsp_ready)  state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // cnt is the hold counter in DRIVE and the pipeline wait counter in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      drv          <= '0;
      cnt          <= '0;
      inv_q        <= 1'b0;
      rsp_vld      <= 1'b0;
      bus.rsp_out  <= '0;
      bus.rsp_leds <= '0;
      bus.rsp_inv  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          drv   <= bus.cmd_data;
          cnt   <= bus.cmd_rep;
          inv_q <= inv;
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            drv <= '0;
            cnt <= 4'(LAT - 1);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            bus.rsp_out  <= bus.alsu_out;
            bus.rsp_leds <= bus.alsu_leds;
            bus.rsp_inv  <= inv_q;
            rsp_vld      <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (bus.rsp_ready) rsp_vld <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef ALSU_CMD_SEQ_ERRCNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= '0;
    else if (state == WAIT && cnt == 4'd0 && inv_q && err_q != 8'hFF)
      err_q <= err_q + 8'd1;
  end
  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Table-driven bench for alsu_cmd_seq with a queue scoreboard of expected responses.
module tb_alsu_cmd_seq;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_err = 0;

  alsu_cmd_seq_if bus ();
  alsu_cmd_seq #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALSU stand-in: result is a known function of the cycle index
  function automatic logic [5:0] pat_out(int k);
    return 6'((k * 7 + 3) & 63);
  endfunction
  function automatic logic [15:0] pat_leds(int k);
    return 16'((k * 40503) & 16'hFFFF) ^ 16'h5a5a;
  endfunction
  assign bus.alsu_out  = pat_out(cyc);
  assign bus.alsu_leds = pat_leds(cyc);

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rep;
    logic        inv;
  } vec_t;

  typedef struct {
    logic [5:0]  out;
    logic [15:0] leds;
    logic        inv;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  function automatic logic [15:0] mk(logic [2:0] a, logic [2:0] b, logic [2:0] op,
      logic cin, logic sin, logic ra, logic rb, logic ba, logic bb, logic dir);
    return {a, b, op, cin, sin, ra, rb, ba, bb, dir};
  endfunction

  function automatic logic [15:0] drives();
    return {bus.alsu_A, bus.alsu_B, bus.alsu_opcode, bus.alsu_cin, bus.alsu_serial_in,
            bus.alsu_red_op_A, bus.alsu_red_op_B, bus.alsu_bypass_A, bus.alsu_bypass_B,
            bus.alsu_direction};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one command, check its drive window, then collect and check its response.
  // hold_cycles > 0 keeps rsp_ready low that long with cmd_valid asserted.
  task automatic run_cmd(vec_t v, int hold_cycles);
    exp_t e, got;
    int   acc;
    int   seen;
    logic [5:0]  o0;
    logic [15:0] l0;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = v.data;
    bus.cmd_rep   = v.rep;
    acc = cyc;
    e.cyc  = acc + int'(v.rep) + 1 + LAT;
    e.out  = pat_out(e.cyc);
    e.leds = pat_leds(e.cyc);
    e.inv  = v.inv;
    sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 16'hFFFF;
    for (int i = 0; i <= int'(v.rep); i++) begin
      chk("drive_held", drives(), v.data);
      chk("cmd_ready_busy", bus.cmd_ready, 0);
      @(negedge clk);
    end
    chk("drive_idle", drives(), 0);
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) begin seen = cyc; break; end
      @(negedge clk);
    end
    chk("rsp_timeout", (seen < 0) ? 1 : 0, 0);
    if (seen < 0) return;
    chk("rsp_latency", seen - 1 - acc, int'(v.rep) + 1 + LAT);
    got = sb.pop_front();
    chk("rsp_out", bus.rsp_out, got.out);
    chk("rsp_leds", bus.rsp_leds, got.leds);
    chk("rsp_inv", bus.rsp_inv, got.inv);
    if (got.inv) exp_err++;
`ifdef ALSU_CMD_SEQ_ERRCNT_EN
    chk("err_cnt", bus.err_cnt, exp_err);
`else
    chk("err_cnt", bus.err_cnt, 0);
`endif
    if (hold_cycles > 0) begin
      o0 = bus.rsp_out;
      l0 = bus.rsp_leds;
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = mk(3'd1, 3'd1, 3'b000, 1, 0, 0, 0, 0, 0, 0);
      bus.cmd_rep   = 4'd0;
      for (int i = 0; i < hold_cycles; i++) begin
        @(negedge clk);
        chk("hold_valid", bus.rsp_valid, 1);
        chk("hold_stable", {bus.rsp_out, bus.rsp_leds}, {o0, l0});
        chk("hold_cmd_ready", bus.cmd_ready, 0);
        chk("hold_no_drive", drives(), 0);
      end
      bus.cmd_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_cleared", bus.rsp_valid, 0);
    chk("cmd_ready_after", bus.cmd_ready, 1);
  endtask

  initial begin
    vecs[0] = '{mk(3'd3, 3'd5, 3'b010, 1, 0, 0, 0, 0, 0, 0), 4'd0,  1'b0};
    vecs[1] = '{mk(3'd0, 3'd0, 3'b100, 0, 1, 0, 0, 0, 0, 1), 4'd2,  1'b0};
    vecs[2] = '{mk(3'd2, 3'd6, 3'b110, 0, 0, 0, 0, 0, 0, 0), 4'd0,  1'b1};
    vecs[3] = '{mk(3'd4, 3'd1, 3'b011, 0, 0, 1, 0, 0, 1, 0), 4'd1,  1'b0};
    vecs[4] = '{mk(3'd4, 3'd1, 3'b011, 0, 0, 1, 0, 0, 0, 0), 4'd0,  1'b1};
    vecs[5] = '{mk(3'd7, 3'd2, 3'b111, 0, 0, 0, 0, 1, 0, 0), 4'd15, 1'b0};
    vecs[6] = '{mk(3'd1, 3'd3, 3'b101, 0, 0, 0, 1, 0, 0, 0), 4'd4,  1'b1};
    vecs[7] = '{mk(3'd5, 3'd5, 3'b001, 1, 0, 1, 0, 0, 0, 0), 4'd0,  1'b0};
    vecs[8] = '{mk(3'd7, 3'd7, 3'b000, 0, 0, 0, 0, 0, 0, 0), 4'd0,  1'b0};

    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_rep   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_drives", drives(), 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_out, bus.rsp_leds, bus.rsp_inv}, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;

    // stray rsp_ready while nothing is buffered
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("stray_ready_valid", bus.rsp_valid, 0);
    chk("stray_ready_cmd_ready", bus.cmd_ready, 1);

    foreach (vecs[i]) run_cmd(vecs[i], 0);

    // backpressure: response held for 10 cycles with a competing command
    run_cmd(vecs[0], 10);

    // reset in the second DRIVE cycle discards the command
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(3'd6, 3'd2, 3'b110, 0, 0, 0, 0, 0, 0, 0);
    bus.cmd_rep   = 4'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("pre_rst_drive", drives(), mk(3'd6, 3'd2, 3'b110, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_drives", drives(), 0);
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
    chk("mid_rst_err_cnt", bus.err_cnt, 0);
    begin
      int hits = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (bus.rsp_valid || drives() != 0) hits++;
      end
      chk("no_rsp_after_rst", hits, 0);
    end
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alsu_cmd_seq.md
# alsu_cmd_seq

Command sequencer that drives the registered ALSU inputs from a valid/ready command stream and returns the ALSU result on a valid/ready response stream. Sits in front of the ALSU in the board-level test harness: accepts one packed command, holds it on the ALSU inputs for a programmable number of cycles (for shift/rotate stepping), waits out the ALSU pipeline, and captures `out`/`leds` into a single-entry response buffer. Also flags commands that the ALSU treats as invalid.

## Interface
- `LAT`, 2: cycles from the last drive cycle to the ALSU result being valid on `alsu_out` (input sample register plus output register).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_data`  in  16  packed command, MSB first:
  - `{A[2:0], B[2:0], opcode[2:0], cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}`.
- `cmd_rep`  in  4  extra hold cycles; the command is driven `cmd_rep+1` cycles.
- `alsu_A`, `alsu_B`, `alsu_opcode`  out  3 each  ALSU operand and opcode drives.
- `alsu_cin`, `alsu_serial_in`, `alsu_red_op_A`, `alsu_red_op_B`, `alsu_bypass_A`, `alsu_bypass_B`, `alsu_direction`  out  1 each  ALSU control drives.
- `alsu_out`  in  6  ALSU result.
- `alsu_leds`  in  16  ALSU LED vector.
- `rsp_valid`  out  1  response buffer full.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_out`  out  6  captured `alsu_out`.
- `rsp_leds`  out  16  captured `alsu_leds`.
- `rsp_inv`  out  1  command predicted invalid.
- `err_cnt`  out  8  saturating invalid-command count (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE → DRIVE on `cmd_valid && cmd_ready`.
  - DRIVE → WAIT when the hold counter reaches 0.
  - WAIT → RESP after `LAT` cycles.
  - RESP → IDLE on `rsp_ready`.
- `cmd_ready` = 1 only in IDLE and only when `rsp_valid` = 0.
- Accept edge:
  - all `alsu_*` drive registers load the command fields;
  - hold counter loads `cmd_rep`;
  - `inv` is computed and latched.
- DRIVE: drives are held, and the counter decrements each cycle. DRIVE lasts exactly `cmd_rep+1` cycles.
- On leaving DRIVE, all `alsu_*` drives return to the idle vector (all zero). They stay at the idle vector through WAIT, RESP and IDLE.
- WAIT: a counter runs `LAT` cycles. On the edge ending the last WAIT cycle:
  - `rsp_out` and `rsp_leds` capture `alsu_out` and `alsu_leds`;
  - `rsp_inv` gets the latched `inv`;
  - `rsp_valid` is set.
- RESP:
  - `rsp_*` held stable while `rsp_valid` = 1 and `rsp_ready` = 0;
  - `rsp_valid` clears on the edge where `rsp_ready` = 1, and the FSM moves to IDLE in the same edge.
- Invalid prediction: `inv = !bypass_A && !bypass_B && (opcode[2:1]==2'b11 || ((red_op_A||red_op_B) && opcode inside 3'b010..3'b101))`.
- Response data is not checked against a model. `rsp_inv` is advisory for the consumer.

## Timing
- Reset values:
  - `cmd_ready` = 1;
  - all `alsu_*` = 0;
  - `rsp_valid` = 0;
  - `rsp_out` = 0, `rsp_leds` = 0, `rsp_inv` = 0;
  - `err_cnt` = 0;
  - FSM in IDLE.
- Command accepted at edge E0:
  - drives are visible from E0 through the last DRIVE cycle;
  - `rsp_valid` rises at edge E0 + `cmd_rep` + 1 + `LAT`.
- Throughput: a new command can be accepted no sooner than 1 cycle after `rsp_valid` falls.
- `rsp_ready` asserted while `rsp_valid` = 0 is ignored.
- `cmd_rep` = 15 is the maximum: the command is driven 16 cycles, with no wrap.
- Reset asserted in any state:
  - the next edge forces all reset values;
  - any in-flight command and buffered response are discarded;
  - no response is emitted for them.
- `cmd_valid` toggling outside IDLE has no effect.

## Configuration
- `ALSU_CMD_SEQ_ERRCNT_EN` defined:
  - `err_cnt` increments on each response capture with `inv` = 1;
  - it saturates at 8'hFF;
  - it clears only on `rst`.
- Not defined: `err_cnt` is tied to 0 and the counter logic is not compiled.

## Test plan
- Reset, then cmd `A=3, B=5, opcode=010, cin=1`, all other controls 0, `cmd_rep=0`:
  - `alsu_*` driven 1 cycle;
  - `rsp_valid` rises 3 edges after accept;
  - `rsp_out` = `alsu_out` at capture (9 with a conforming ALSU), `rsp_inv` = 0.
- Cmd `opcode=100, direction=1, serial_in=1, cmd_rep=2`:
  - drives held exactly 3 cycles, then zero;
  - `rsp_valid` rises 5 edges after accept.
- Cmd `opcode=110`:
  - `rsp_inv` = 1;
  - with the macro defined, `err_cnt` goes 0→1.
- Cmd `opcode=011, red_op_A=1, bypass_B=1`: `rsp_inv` = 0, because bypass overrides.
- Hold `rsp_ready` = 0 for 10 cycles after `rsp_valid`:
  - `rsp_*` stable;
  - `cmd_ready` = 0 throughout, and a second `cmd_valid` is not accepted.
  - After `rsp_ready` pulses: `cmd_ready` = 1 next cycle.
- Assert `rst` in the second DRIVE cycle of `cmd_rep=3`:
  - next edge: all `alsu_*` = 0, `rsp_valid` = 0, `cmd_ready` = 1;
  - no response ever appears.
